load_store_unit: RTL and testbench

// Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address
// and runs one load or store per request over a valid/ready data-memory bus.
// - Stores: replicates data onto byte lanes and generates byte enables.
// - Loads: extracts the addressed lane and sign/zero-extends it.
// - Flags misaligned and illegal accesses without touching the bus, and bounds bus stalls with a timeout.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: address checks, byte-lane steering and a valid/ready memory bus.
// Loads are sign/zero-extended; stalls in REQ or WAIT_RDATA are bounded by a timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_isStore,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_address,
  input  logic [31:0] i_storeData,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_error,
  output logic [31:0] o_loadData,
  output logic        o_memValid,
  input  logic        i_memReady,
  output logic        o_memWrite,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWdata,
  output logic [3:0]  o_memByteEn,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  r_state;
  logic        r_isStore;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [1:0]  r_err;
  logic [31:0] r_loadData;
  logic [CW-1:0] r_cnt;

  logic        w_illegal;
  logic        w_misal;
  logic        w_tmo;
  logic [31:0] w_shift;
  logic [31:0] w_ext;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;

  assign w_illegal = i_isStore ? (i_funct3 > 3'd2)
                   : (i_funct3 == 3'd3 || i_funct3 >= 3'd6);
  assign w_misal = (i_funct3[1:0] == 2'd1 && i_address[0])
                 || (i_funct3[1:0] == 2'd2 && i_address[1:0] != 2'd0);
  assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Accesses are aligned, so shifting by the byte offset lands the lane at bit 0
  assign w_shift = i_memRdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_shift;
    case (r_funct3)
      3'd0:    w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'd1:    w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'd4:    w_ext = {24'd0, w_shift[7:0]};
      3'd5:    w_ext = {16'd0, w_shift[15:0]};
      default: w_ext = i_memRdata;
    endcase
  end

  always_comb begin
    w_wdata = r_sdata;
    w_be    = 4'b1111;
    case (r_funct3[1:0])
      2'd0: begin
        w_wdata = {4{r_sdata[7:0]}};
        w_be    = 4'b0001 << r_addr[1:0];
      end
      2'd1: begin
        w_wdata = {2{r_sdata[15:0]}};
        w_be    = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_wdata = r_sdata;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_isStore  <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_sdata    <= 32'd0;
      r_err      <= 2'd0;
      r_loadData <= 32'd0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_isStore <= i_isStore;
            r_funct3  <= i_funct3;
            r_addr    <= i_address;
            r_sdata   <= i_storeData;
            r_cnt     <= '0;
            if (w_illegal || w_misal) begin
              r_err   <= w_illegal ? 2'b10 : 2'b01;
              r_state <= S_DONE;
              if (!i_isStore) r_loadData <= 32'd0;
            end else begin
              r_err   <= 2'b00;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_memReady) begin
            r_cnt   <= '0;
            r_state <= r_isStore ? S_DONE : S_WAIT;
          end else if (w_tmo) begin
            r_err   <= 2'b11;
            r_state <= S_DONE;
            if (!r_isStore) r_loadData <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_memRvalid) begin
            r_loadData <= w_ext;
            r_state    <= S_DONE;
          end else if (w_tmo) begin
            r_err      <= 2'b11;
            r_loadData <= 32'd0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_error     = o_done ? r_err : 2'b00;
  assign o_loadData  = r_loadData;
  assign o_memValid  = (r_state == S_REQ);
  assign o_memWrite  = r_isStore;
  assign o_memAddr   = {r_addr[31:2], 2'b00};
  assign o_memWdata  = w_wdata;
  assign o_memByteEn = r_isStore ? w_be : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected results queued at issue,
// popped and compared when o_done fires.
module tb_load_store_unit;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [1:0]  err;
    logic        keep;
    logic [31:0] ld;
    int          lat;
    int          nv;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [3:0]  be;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic        i_isStore = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_address = 32'd0;
  logic [31:0] i_storeData = 32'd0;
  logic        o_busy, o_done, o_memValid, o_memWrite;
  logic [1:0]  o_error;
  logic [31:0] o_loadData, o_memAddr, o_memWdata;
  logic [3:0]  o_memByteEn;
  logic        i_memReady = 1'b1;
  logic        i_memRvalid = 1'b1;
  logic [31:0] i_memRdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cur_ld = 32'd0;
  vec_t sb[$];

  always #5 i_clk = ~i_clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_isStore(i_isStore), .i_funct3(i_funct3),
    .i_address(i_address), .i_storeData(i_storeData),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_loadData(o_loadData), .o_memValid(o_memValid),
    .i_memReady(i_memReady), .o_memWrite(o_memWrite),
    .o_memAddr(o_memAddr), .o_memWdata(o_memWdata),
    .o_memByteEn(o_memByteEn), .i_memRvalid(i_memRvalid),
    .i_memRdata(i_memRdata)
  );

  // Drives one request (accept edge = cycle 0) and waits, bounded, for o_done.
  task automatic run(input vec_t v, input logic hold,
                     output int lat, output int nv,
                     output logic [31:0] a, output logic [31:0] wd,
                     output logic [3:0] be, output logic wr);
    if (v.keep) v.ld = cur_ld;
    sb.push_back(v);
    @(negedge i_clk);
    i_isStore = v.st; i_funct3 = v.f3;
    i_address = v.addr; i_storeData = v.sd;
    i_memRdata = v.rd; i_req = 1'b1;
    @(negedge i_clk);
    i_req = hold;
    if (hold) begin
      i_isStore = 1'b0; i_funct3 = 3'd2; i_address = 32'h500;
    end
    lat = 1; nv = 0; a = 0; wd = 0; be = 0; wr = 0;
    while (!o_done && lat < 40) begin
      if (o_memValid) begin
        if (nv == 0) begin
          a = o_memAddr; wd = o_memWdata; be = o_memByteEn; wr = o_memWrite;
        end
        nv++;
      end
      @(negedge i_clk);
      lat++;
    end
    i_req = 1'b0;
  endtask

  task automatic check_vecs(input string tag, input vec_t vs[$], input logic hold);
    int lat, nv;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic wr;
    vec_t e;
    foreach (vs[i]) begin
      run(vs[i], hold, lat, nv, a, wd, be, wr);
      e = sb.pop_front();
      vectors++;
      if (lat !== e.lat || o_error !== e.err || o_loadData !== e.ld || nv !== e.nv) begin
        miscompares++;
        $display("FAIL %s[%0d] done: lat=%0d err=%b ld=%h nv=%0d required lat=%0d err=%b ld=%h nv=%0d",
                 tag, i, lat, o_error, o_loadData, nv, e.lat, e.err, e.ld, e.nv);
      end
      if (nv > 0) begin
        vectors++;
        if (a !== e.ma || be !== e.be || wr !== e.st || (e.st && wd !== e.wd)) begin
          miscompares++;
          $display("FAIL %s[%0d] bus: addr=%h wdata=%h be=%b wr=%b required addr=%h wdata=%h be=%b wr=%b",
                   tag, i, a, wd, be, wr, e.ma, e.wd, e.be, e.st);
        end
      end
      cur_ld = e.ld;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({o_busy, o_done, o_error, o_loadData, o_memValid, o_memWrite,
         o_memAddr, o_memWdata, o_memByteEn} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b ld=%h valid=%b addr=%h be=%b required all zero",
               o_busy, o_done, o_error, o_loadData, o_memValid, o_memAddr, o_memByteEn);
    end
  endtask

  task automatic test_load();
    vec_t vs[$];
    i_memReady = 1'b1; i_memRvalid = 1'b1;
    vs.push_back('{0,3'd2,32'h100,0,32'hDEADBEEF,2'b00,0,32'hDEADBEEF,3,1,32'h100,0,4'b0000});
    vs.push_back('{0,3'd0,32'h103,0,32'h80FF1234,2'b00,0,32'hFFFFFF80,3,1,32'h100,0,4'b0000});
    vs.push_back('{0,3'd4,32'h103,0,32'h80FF1234,2'b00,0,32'h00000080,3,1,32'h100,0,4'b0000});
    vs.push_back('{0,3'd5,32'h102,0,32'h80FF1234,2'b00,0,32'h000080FF,3,1,32'h100,0,4'b0000});
    vs.push_back('{0,3'd1,32'h102,0,32'h80FF1234,2'b00,0,32'hFFFF80FF,3,1,32'h100,0,4'b0000});
    vs.push_back('{0,3'd0,32'h101,0,32'h80FF1234,2'b00,0,32'h00000012,3,1,32'h100,0,4'b0000});
    vs.push_back('{0,3'd1,32'h108,0,32'h0000F00F,2'b00,0,32'hFFFFF00F,3,1,32'h108,0,4'b0000});
    check_vecs("load", vs, 1'b0);
  endtask

  task automatic test_store();
    vec_t vs[$];
    vs.push_back('{1,3'd0,32'h201,32'h000000A5,0,2'b00,1,0,2,1,32'h200,32'hA5A5A5A5,4'b0010});
    vs.push_back('{1,3'd1,32'h202,32'h1234BEEF,0,2'b00,1,0,2,1,32'h200,32'hBEEFBEEF,4'b1100});
    vs.push_back('{1,3'd2,32'h204,32'h11223344,0,2'b00,1,0,2,1,32'h204,32'h11223344,4'b1111});
    vs.push_back('{1,3'd0,32'h203,32'hFFFFFF7E,0,2'b00,1,0,2,1,32'h200,32'h7E7E7E7E,4'b1000});
    check_vecs("store", vs, 1'b0);
  endtask

  task automatic test_errors();
    vec_t vs[$];
    vs.push_back('{1,3'd3,32'h200,32'h5,0,2'b10,1,0,1,0,0,0,0});
    vs.push_back('{1,3'd1,32'h203,32'h5,0,2'b01,1,0,1,0,0,0,0});
    vs.push_back('{0,3'd2,32'h102,0,32'h1,2'b01,0,0,1,0,0,0,0});
    vs.push_back('{0,3'd3,32'h101,0,32'h1,2'b10,0,0,1,0,0,0,0});
    vs.push_back('{0,3'd5,32'h105,0,32'h1,2'b01,0,0,1,0,0,0,0});
    vs.push_back('{0,3'd7,32'h100,0,32'h1,2'b10,0,0,1,0,0,0,0});
    check_vecs("error", vs, 1'b0);
  endtask

  task automatic test_timeout();
    vec_t vs[$];
    vs.push_back('{0,3'd0,32'h0,0,32'h00000055,2'b00,0,32'h55,3,1,32'h0,0,4'b0000});
    check_vecs("pre_timeout", vs, 1'b0);
    vs.delete();
    i_memReady = 1'b0;
    vs.push_back('{1,3'd2,32'h300,32'hCAFE0001,0,2'b11,1,0,5,4,32'h300,32'hCAFE0001,4'b1111});
    check_vecs("timeout_req", vs, 1'b1);
    @(negedge i_clk);
    vectors++;
    if (o_busy !== 1'b0 || o_memValid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_req_ignored: busy=%b valid=%b required 0 0", o_busy, o_memValid);
    end
    vs.delete();
    i_memReady = 1'b1; i_memRvalid = 1'b0;
    vs.push_back('{0,3'd2,32'h304,0,32'h77,2'b11,0,0,6,1,32'h304,0,4'b0000});
    check_vecs("timeout_rdata", vs, 1'b0);
    i_memRvalid = 1'b1;
  endtask

  task automatic test_reset_mid();
    int seen;
    vec_t vs[$];
    i_memReady = 1'b1; i_memRvalid = 1'b0;
    @(negedge i_clk);
    i_isStore = 1'b0; i_funct3 = 3'd2; i_address = 32'h400; i_req = 1'b1;
    @(negedge i_clk);
    i_req = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    vectors++;
    if ({o_busy, o_done, o_error, o_loadData, o_memValid, o_memWrite,
         o_memAddr, o_memWdata, o_memByteEn} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b ld=%h addr=%h required all zero",
               o_busy, o_done, o_loadData, o_memAddr);
    end
    seen = 0;
    i_memRvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: active_cycles=%0d required 0", seen);
    end
    cur_ld = 32'd0;
    vs.push_back('{0,3'd2,32'h404,0,32'hCAFEF00D,2'b00,0,32'hCAFEF00D,3,1,32'h404,0,4'b0000});
    check_vecs("after_reset", vs, 1'b0);
  endtask

  task automatic test_back_to_back();
    vec_t vs[$];
    vs.push_back('{1,3'd1,32'h600,32'h0000ABCD,0,2'b00,1,0,2,1,32'h600,32'hABCDABCD,4'b0011});
    vs.push_back('{0,3'd4,32'h602,0,32'h00C30000,2'b00,0,32'h000000C3,3,1,32'h600,0,4'b0000});
    vs.push_back('{0,3'd0,32'h602,0,32'h00C30000,2'b00,0,32'hFFFFFFC3,3,1,32'h600,0,4'b0000});
    check_vecs("b2b", vs, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
